// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the spi_slave_rx receiver.
package spi_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } rx_state_t;

  localparam int SPI_FRAME_BITS_DEF = 24;
  localparam int SPI_SYNC_STAGES    = 2;

  typedef logic [SPI_FRAME_BITS_DEF-1:0] spi_frame_t;

endpackage

// File: rtl/spi_rx_sync.sv
// Pin conditioning for spi_slave_rx: optional synchronizers (SPI_RX_SYNC_EN) plus
// one registered edge-detect stage producing single-cycle event pulses.
module spi_rx_sync
  import spi_rx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic spi_clock,
  input  logic spi_data,
  input  logic cs_n,
  output logic data_s,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise
);

  logic sclk_in;
  logic data_in;
  logic cs_in;
  logic sclk_prev;
  logic cs_prev;

`ifdef SPI_RX_SYNC_EN
  logic [SPI_SYNC_STAGES-1:0] sclk_sync;
  logic [SPI_SYNC_STAGES-1:0] data_sync;
  logic [SPI_SYNC_STAGES-1:0] cs_sync;

  // cs_n resets to its idle level so releasing reset never fakes a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      data_sync <= '0;
      cs_sync   <= '1;
    end else begin
      sclk_sync <= {sclk_sync[SPI_SYNC_STAGES-2:0], spi_clock};
      data_sync <= {data_sync[SPI_SYNC_STAGES-2:0], spi_data};
      cs_sync   <= {cs_sync[SPI_SYNC_STAGES-2:0], cs_n};
    end
  end

  assign sclk_in = sclk_sync[SPI_SYNC_STAGES-1];
  assign data_in = data_sync[SPI_SYNC_STAGES-1];
  assign cs_in   = cs_sync[SPI_SYNC_STAGES-1];
`else
  assign sclk_in = spi_clock;
  assign data_in = spi_data;
  assign cs_in   = cs_n;
`endif

  // data_s is registered alongside the pulses so it is the bit present at the sclk fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
      data_s    <= 1'b0;
      sclk_fall <= 1'b0;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
    end else begin
      sclk_prev <= sclk_in;
      cs_prev   <= cs_in;
      data_s    <= data_in;
      sclk_fall <= sclk_prev & ~sclk_in;
      cs_fall   <= cs_prev & ~cs_in;
      cs_rise   <= ~cs_prev & cs_in;
    end
  end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: assembles MSB-first frames and offers them on a valid/ready port.
// Define SPI_RX_SYNC_EN to insert 2-flop input synchronizers for asynchronous pins.
module spi_slave_rx
  import spi_rx_pkg::*;
#(
  parameter int FRAME_BITS = SPI_FRAME_BITS_DEF,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_clock,
  input  logic                  spi_data,
  input  logic                  cs_n,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy,
  output logic                  status_led
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);

  logic data_s;
  logic sclk_fall;
  logic cs_fall;
  logic cs_rise;

  rx_state_t             state;
  rx_state_t             next_state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [FRAME_BITS-1:0] frame_next;
  logic                  extra;

  logic start;
  logic capture;
  logic deliver;
  logic short_err;
  logic hold_err;
  logic set_extra;
  logic clr_extra;

  spi_rx_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_clock (spi_clock),
    .spi_data  (spi_data),
    .cs_n      (cs_n),
    .data_s    (data_s),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise)
  );

  assign frame_next = {shift_reg[FRAME_BITS-2:0], data_s};
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // The last bit is delivered straight from frame_next so rx_valid follows the capture edge.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    capture    = 1'b0;
    deliver    = 1'b0;
    short_err  = 1'b0;
    hold_err   = 1'b0;
    set_extra  = 1'b0;
    clr_extra  = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          next_state = SHIFT;
          start      = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          next_state = IDLE;
          short_err  = (bit_cnt != '0);
        end else if (sclk_fall) begin
          capture = 1'b1;
          if (bit_cnt == LAST_CNT) begin
            deliver    = 1'b1;
            next_state = HOLD;
          end
        end
      end
      HOLD: begin
        if (cs_rise) begin
          next_state = IDLE;
          hold_err   = extra;
          clr_extra  = 1'b1;
        end else if (sclk_fall) begin
          set_extra = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      extra     <= 1'b0;
    end else begin
      if (start) begin
        bit_cnt   <= '0;
        shift_reg <= '0;
      end else if (capture) begin
        shift_reg <= frame_next;
        if (bit_cnt != FULL_CNT) bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (start || clr_extra) extra <= 1'b0;
      else if (set_extra)     extra <= 1'b1;
    end
  end

  // A frame is only accepted when the output slot is empty or being drained this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      status_led <= 1'b0;
    end else begin
      frame_err <= short_err | hold_err;
      overrun   <= 1'b0;
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data    <= frame_next;
        rx_valid   <= 1'b1;
        status_led <= 1'b1;
      end else begin
        if (rx_valid && rx_ready) rx_valid <= 1'b0;
        if (deliver)              overrun  <= 1'b1;
      end
    end
  end

endmodule
